// File: rtl/cd_ram_ring.sv
// cd_ram_ring: multi-page packet buffer ring between a byte-wide framer port
// and a 32-bit memory-mapped host port. The writer fills the current page and
// commits it with switch; the reader releases committed pages in order. Each
// committed page carries a hardware-tracked byte length and a flags byte.
module cd_ram_ring #(
    parameter int A_WIDTH = 6,
    parameter int P_WIDTH = 1,
    parameter int MM4RX   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [A_WIDTH-1:0]   mm_address,
    input  logic [3:0]           mm_byteenable,
    input  logic                 mm_read,
    output logic [31:0]          mm_readdata,
    input  logic                 mm_write,
    input  logic [31:0]          mm_writedata,
    output logic [7:0]           rd_byte,
    input  logic [A_WIDTH+1:0]   rd_addr,
    input  logic                 rd_en,
    input  logic                 rd_done,
    input  logic                 rd_done_all,
    input  logic [7:0]           wr_byte,
    input  logic [A_WIDTH+1:0]   wr_addr,
    input  logic                 wr_en,
    input  logic                 wr_abort,
    input  logic                 switch,
    input  logic [7:0]           wr_flags,
    output logic [7:0]           rd_flags,
    output logic [A_WIDTH+2:0]   rd_len,
    output logic [P_WIDTH:0]     pending,
    output logic                 unread,
    output logic                 full,
    output logic                 switch_fail,
    output logic [7:0]           drop_cnt,
    input  logic                 drop_clr
);

    localparam int PAGES = 2 ** P_WIDTH;
    localparam int MW    = P_WIDTH + A_WIDTH;
    localparam int DEPTH = 2 ** MW;
    localparam int LW    = A_WIDTH + 3;
    localparam int PW    = P_WIDTH + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(PAGES - 1);

    // Index of the highest enabled byte lane (0 when no lane is enabled).
    function automatic logic [1:0] top_lane(input logic [3:0] be);
        logic [1:0] idx;
        casez (be)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [7:0]         mem_r [4][DEPTH];
    logic [P_WIDTH-1:0] wr_sel_r, rd_sel_r, wr_sel_nxt_s, rd_sel_nxt_s;
    logic [PW-1:0]      pending_r, pend_nxt_s;
    logic [LW-1:0]      len_r, len_nxt_s, len_upd_s, wr_last_s, wr_len_s;
    logic [7:0]         drop_r, drop_nxt_s;
    logic [7:0]         flags_mem_r [PAGES];
    logic [LW-1:0]      len_mem_r [PAGES];
    logic [7:0]         rd_flags_r, flags_nxt_s;
    logic [LW-1:0]      rd_len_r, rdlen_nxt_s;
    logic               full_r, unread_r, switch_fail_r;
    logic [31:0]        mm_readdata_r;
    logic [7:0]         rd_byte_r;
    logic [3:0]         we_s;
    logic [31:0]        wdata_s;
    logic [MW-1:0]      waddr_s, mm_raddr_s, b_raddr_s;
    logic               full_now_s, sw_ok_s, sw_fail_s, rel_ok_s;

    // Route the active write port (byte side for RX, mm side for TX) to the RAM
    always_comb begin
        we_s      = 4'b0000;
        wdata_s   = 32'h0000_0000;
        waddr_s   = '0;
        wr_last_s = '0;
        if (MM4RX != 0) begin
            if (wr_en) begin
                we_s = 4'b0001 << wr_addr[1:0];
            end else begin
                we_s = 4'b0000;
            end
            wdata_s   = {4{wr_byte}};
            waddr_s   = {wr_sel_r, wr_addr[A_WIDTH+1:2]};
            wr_last_s = {1'b0, wr_addr};
        end else begin
            if (mm_write) begin
                we_s = mm_byteenable;
            end else begin
                we_s = 4'b0000;
            end
            wdata_s   = mm_writedata;
            waddr_s   = {wr_sel_r, mm_address};
            wr_last_s = {1'b0, mm_address, top_lane(mm_byteenable)};
        end
    end

    // Read addresses: the mm side follows the reader page for RX, the writer page for TX
    always_comb begin
        b_raddr_s = {rd_sel_r, rd_addr[A_WIDTH+1:2]};
        if (MM4RX != 0) begin
            mm_raddr_s = {rd_sel_r, mm_address};
        end else begin
            mm_raddr_s = {wr_sel_r, mm_address};
        end
    end

    // Length tracker update and the switch / release / flush decisions
    always_comb begin
        wr_len_s = wr_last_s + LW'(1);
        if ((we_s != 4'b0000) && (wr_len_s > len_r)) begin
            len_upd_s = wr_len_s;
        end else begin
            len_upd_s = len_r;
        end
        full_now_s = (pending_r == FULL_LVL);
        sw_fail_s  = switch && full_now_s && !rd_done_all;
        sw_ok_s    = switch && !full_now_s && !rd_done_all;
        rel_ok_s   = rd_done && (pending_r != '0) && !rd_done_all;
    end

    // Next pointer, pending, tracker and drop-counter values
    always_comb begin
        wr_sel_nxt_s = wr_sel_r;
        rd_sel_nxt_s = rd_sel_r;
        pend_nxt_s   = pending_r;
        len_nxt_s    = len_upd_s;
        drop_nxt_s   = drop_r;
        if (rd_done_all) begin
            wr_sel_nxt_s = '0;
            rd_sel_nxt_s = '0;
            pend_nxt_s   = '0;
            len_nxt_s    = '0;
        end else begin
            if (sw_ok_s) begin
                wr_sel_nxt_s = wr_sel_r + P_WIDTH'(1);
            end else begin
                wr_sel_nxt_s = wr_sel_r;
            end
            if (rel_ok_s) begin
                rd_sel_nxt_s = rd_sel_r + P_WIDTH'(1);
            end else begin
                rd_sel_nxt_s = rd_sel_r;
            end
            if (sw_ok_s && !rel_ok_s) begin
                pend_nxt_s = pending_r + PW'(1);
            end else if (!sw_ok_s && rel_ok_s) begin
                pend_nxt_s = pending_r - PW'(1);
            end else begin
                pend_nxt_s = pending_r;
            end
            if (switch || wr_abort) begin
                len_nxt_s = '0;
            end else begin
                len_nxt_s = len_upd_s;
            end
        end
        if (drop_clr) begin
            drop_nxt_s = sw_fail_s ? 8'd1 : 8'd0;
        end else if (sw_fail_s && (drop_r != 8'hFF)) begin
            drop_nxt_s = drop_r + 8'd1;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Oldest-page metadata as it will be after this cycle; a same-cycle commit into that page is forwarded
    always_comb begin
        flags_nxt_s = 8'h00;
        rdlen_nxt_s = '0;
        if (pend_nxt_s == '0) begin
            flags_nxt_s = 8'h00;
            rdlen_nxt_s = '0;
        end else if (sw_ok_s && (wr_sel_r == rd_sel_nxt_s)) begin
            flags_nxt_s = wr_flags;
            rdlen_nxt_s = len_upd_s;
        end else begin
            flags_nxt_s = flags_mem_r[rd_sel_nxt_s];
            rdlen_nxt_s = len_mem_r[rd_sel_nxt_s];
        end
    end

    // Control state, page metadata and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel_r      <= '0;
            rd_sel_r      <= '0;
            pending_r     <= '0;
            len_r         <= '0;
            drop_r        <= 8'd0;
            switch_fail_r <= 1'b0;
            full_r        <= 1'b0;
            unread_r      <= 1'b0;
            rd_flags_r    <= 8'h00;
            rd_len_r      <= '0;
            for (int p = 0; p < PAGES; p++) begin
                flags_mem_r[p] <= 8'h00;
                len_mem_r[p]   <= '0;
            end
        end else begin
            wr_sel_r      <= wr_sel_nxt_s;
            rd_sel_r      <= rd_sel_nxt_s;
            pending_r     <= pend_nxt_s;
            len_r         <= len_nxt_s;
            drop_r        <= drop_nxt_s;
            switch_fail_r <= sw_fail_s;
            full_r        <= (pend_nxt_s == FULL_LVL);
            unread_r      <= (pend_nxt_s != '0);
            rd_flags_r    <= flags_nxt_s;
            rd_len_r      <= rdlen_nxt_s;
            if (sw_ok_s) begin
                flags_mem_r[wr_sel_r] <= wr_flags;
                len_mem_r[wr_sel_r]   <= len_upd_s;
            end
        end
    end

    // Byte-lane RAM write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we_s[l]) begin
                mem_r[l][waddr_s] <= wdata_s[l*8 +: 8];
            end
        end
    end

    // Registered read ports; old data is returned on a same-address write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_readdata_r <= 32'h0000_0000;
            rd_byte_r     <= 8'h00;
        end else begin
            if (mm_read) begin
                mm_readdata_r <= {mem_r[3][mm_raddr_s], mem_r[2][mm_raddr_s],
                                  mem_r[1][mm_raddr_s], mem_r[0][mm_raddr_s]};
            end
            if (rd_en && (MM4RX == 0)) begin
                rd_byte_r <= mem_r[rd_addr[1:0]][b_raddr_s];
            end
        end
    end

    assign mm_readdata = mm_readdata_r;
    assign rd_byte     = rd_byte_r;
    assign rd_flags    = rd_flags_r;
    assign rd_len      = rd_len_r;
    assign pending     = pending_r;
    assign unread      = unread_r;
    assign full        = full_r;
    assign switch_fail = switch_fail_r;
    assign drop_cnt    = drop_r;

endmodule

// File: tb/tb_cd_ram_ring.sv
// Bench for cd_ram_ring: an RX ring (4 pages) driven from a vector table and a
// TX ring (2 pages) driven by a hand-written sequence. Read data is checked
// through expectation queues filled when the read strobe is driven.
module tb_cd_ram_ring;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- RX instance: MM4RX=1, P_WIDTH=2 ----------------
    logic [5:0]  rx_mm_address = '0;
    logic [3:0]  rx_mm_byteenable = '0;
    logic        rx_mm_read = 1'b0, rx_mm_write = 1'b0;
    logic [31:0] rx_mm_writedata = '0, rx_mm_readdata;
    logic [7:0]  rx_rd_byte, rx_wr_byte = '0, rx_wr_flags = '0, rx_rd_flags, rx_drop_cnt;
    logic [7:0]  rx_rd_addr = '0, rx_wr_addr = '0;
    logic        rx_rd_en = 1'b0, rx_rd_done = 1'b0, rx_rd_done_all = 1'b0;
    logic        rx_wr_en = 1'b0, rx_wr_abort = 1'b0, rx_switch = 1'b0, rx_drop_clr = 1'b0;
    logic [8:0]  rx_rd_len;
    logic [2:0]  rx_pending;
    logic        rx_unread, rx_full, rx_switch_fail;

    cd_ram_ring #(.A_WIDTH(6), .P_WIDTH(2), .MM4RX(1)) u_rx (
        .clk(clk), .reset_n(reset_n),
        .mm_address(rx_mm_address), .mm_byteenable(rx_mm_byteenable),
        .mm_read(rx_mm_read), .mm_readdata(rx_mm_readdata),
        .mm_write(rx_mm_write), .mm_writedata(rx_mm_writedata),
        .rd_byte(rx_rd_byte), .rd_addr(rx_rd_addr), .rd_en(rx_rd_en),
        .rd_done(rx_rd_done), .rd_done_all(rx_rd_done_all),
        .wr_byte(rx_wr_byte), .wr_addr(rx_wr_addr), .wr_en(rx_wr_en),
        .wr_abort(rx_wr_abort), .switch(rx_switch), .wr_flags(rx_wr_flags),
        .rd_flags(rx_rd_flags), .rd_len(rx_rd_len), .pending(rx_pending),
        .unread(rx_unread), .full(rx_full), .switch_fail(rx_switch_fail),
        .drop_cnt(rx_drop_cnt), .drop_clr(rx_drop_clr)
    );

    // ---------------- TX instance: MM4RX=0, P_WIDTH=1 ----------------
    logic [5:0]  tx_mm_address = '0;
    logic [3:0]  tx_mm_byteenable = '0;
    logic        tx_mm_read = 1'b0, tx_mm_write = 1'b0;
    logic [31:0] tx_mm_writedata = '0, tx_mm_readdata;
    logic [7:0]  tx_rd_byte, tx_wr_byte = '0, tx_wr_flags = '0, tx_rd_flags, tx_drop_cnt;
    logic [7:0]  tx_rd_addr = '0, tx_wr_addr = '0;
    logic        tx_rd_en = 1'b0, tx_rd_done = 1'b0, tx_rd_done_all = 1'b0;
    logic        tx_wr_en = 1'b0, tx_wr_abort = 1'b0, tx_switch = 1'b0, tx_drop_clr = 1'b0;
    logic [8:0]  tx_rd_len;
    logic [1:0]  tx_pending;
    logic        tx_unread, tx_full, tx_switch_fail;

    cd_ram_ring #(.A_WIDTH(6), .P_WIDTH(1), .MM4RX(0)) u_tx (
        .clk(clk), .reset_n(reset_n),
        .mm_address(tx_mm_address), .mm_byteenable(tx_mm_byteenable),
        .mm_read(tx_mm_read), .mm_readdata(tx_mm_readdata),
        .mm_write(tx_mm_write), .mm_writedata(tx_mm_writedata),
        .rd_byte(tx_rd_byte), .rd_addr(tx_rd_addr), .rd_en(tx_rd_en),
        .rd_done(tx_rd_done), .rd_done_all(tx_rd_done_all),
        .wr_byte(tx_wr_byte), .wr_addr(tx_wr_addr), .wr_en(tx_wr_en),
        .wr_abort(tx_wr_abort), .switch(tx_switch), .wr_flags(tx_wr_flags),
        .rd_flags(tx_rd_flags), .rd_len(tx_rd_len), .pending(tx_pending),
        .unread(tx_unread), .full(tx_full), .switch_fail(tx_switch_fail),
        .drop_cnt(tx_drop_cnt), .drop_clr(tx_drop_clr)
    );

    // Vector op bits
    localparam logic [7:0] OP_WR  = 8'h01;
    localparam logic [7:0] OP_SW  = 8'h02;
    localparam logic [7:0] OP_DN  = 8'h04;
    localparam logic [7:0] OP_ALL = 8'h08;
    localparam logic [7:0] OP_AB  = 8'h10;
    localparam logic [7:0] OP_MRD = 8'h20;
    localparam logic [7:0] OP_CLR = 8'h40;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  a;
        logic [7:0]  d;
        logic [7:0]  fl;
        logic [2:0]  e_pend;
        logic        e_fail;
        logic [8:0]  e_len;
        logic [7:0]  e_flags;
        logic [7:0]  e_drop;
        logic [31:0] e_rd;
        logic [31:0] e_mask;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
    } rd_exp_t;

    vec_t        tbl[$];
    rd_exp_t     rxq[$];
    logic [31:0] txq_mm[$];
    logic [7:0]  txq_b[$];

    function automatic vec_t mk(input logic [7:0] op, a, d, fl,
                                input logic [2:0] p, input logic f,
                                input logic [8:0] len, input logic [7:0] flg, drop,
                                input logic [31:0] rd, mask);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.fl = fl;
        v.e_pend = p; v.e_fail = f; v.e_len = len; v.e_flags = flg;
        v.e_drop = drop; v.e_rd = rd; v.e_mask = mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic rx_idle();
        rx_wr_en = 1'b0; rx_switch = 1'b0; rx_rd_done = 1'b0; rx_rd_done_all = 1'b0;
        rx_wr_abort = 1'b0; rx_mm_read = 1'b0; rx_drop_clr = 1'b0;
    endtask

    task automatic tx_idle();
        tx_mm_write = 1'b0; tx_mm_read = 1'b0; tx_rd_en = 1'b0; tx_wr_en = 1'b0;
        tx_switch = 1'b0; tx_rd_done = 1'b0; tx_rd_done_all = 1'b0;
        tx_wr_abort = 1'b0; tx_drop_clr = 1'b0;
    endtask

    // Drive one vector into the RX ring, clock it, compare status and any read data
    task automatic apply_rx(input int idx, input vec_t v);
        rd_exp_t e;
        rx_wr_en       = v.op[0];
        rx_switch      = v.op[1];
        rx_rd_done     = v.op[2];
        rx_rd_done_all = v.op[3];
        rx_wr_abort    = v.op[4];
        rx_mm_read     = v.op[5];
        rx_drop_clr    = v.op[6];
        rx_wr_addr     = v.a;
        rx_mm_address  = v.a[5:0];
        rx_wr_byte     = v.d;
        rx_wr_flags    = v.fl;
        if (v.op[5]) begin
            e.d = v.e_rd;
            e.m = v.e_mask;
            rxq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pending", idx), 32'(rx_pending), 32'(v.e_pend));
        chk($sformatf("v%0d full", idx), 32'(rx_full), 32'(v.e_pend == 3'd3));
        chk($sformatf("v%0d unread", idx), 32'(rx_unread), 32'(v.e_pend != 3'd0));
        chk($sformatf("v%0d switch_fail", idx), 32'(rx_switch_fail), 32'(v.e_fail));
        chk($sformatf("v%0d rd_len", idx), 32'(rx_rd_len), 32'(v.e_len));
        chk($sformatf("v%0d rd_flags", idx), 32'(rx_rd_flags), 32'(v.e_flags));
        chk($sformatf("v%0d drop_cnt", idx), 32'(rx_drop_cnt), 32'(v.e_drop));
        if (v.op[5]) begin
            if (rxq.size() == 0) begin
                chk($sformatf("v%0d rx scoreboard empty", idx), 32'd0, 32'd1);
            end else begin
                e = rxq.pop_front();
                chk($sformatf("v%0d mm_readdata", idx), rx_mm_readdata & e.m, e.d & e.m);
            end
        end
        rx_idle();
    endtask

    // Clock the TX ring once and compare any reads issued in this cycle
    task automatic tx_tick(input string tag);
        logic did_mm, did_b;
        logic [31:0] em;
        logic [7:0]  eb;
        did_mm = tx_mm_read;
        did_b  = tx_rd_en;
        @(posedge clk);
        #1;
        if (did_mm) begin
            if (txq_mm.size() == 0) begin
                chk({tag, " tx mm scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                em = txq_mm.pop_front();
                chk({tag, " tx mm_readdata"}, tx_mm_readdata, em);
            end
        end
        if (did_b) begin
            if (txq_b.size() == 0) begin
                chk({tag, " tx byte scoreboard empty"}, 32'd0, 32'd1);
            end else begin
                eb = txq_b.pop_front();
                chk({tag, " tx rd_byte"}, 32'(tx_rd_byte), 32'(eb));
            end
        end
        tx_idle();
    endtask

    task automatic tx_state(input string tag, input logic [1:0] p, input logic f,
                            input logic [8:0] len, input logic [7:0] flg, input logic [7:0] drop);
        chk({tag, " tx pending"}, 32'(tx_pending), 32'(p));
        chk({tag, " tx full"}, 32'(tx_full), 32'(p == 2'd1));
        chk({tag, " tx unread"}, 32'(tx_unread), 32'(p != 2'd0));
        chk({tag, " tx switch_fail"}, 32'(tx_switch_fail), 32'(f));
        chk({tag, " tx rd_len"}, 32'(tx_rd_len), 32'(len));
        chk({tag, " tx rd_flags"}, 32'(tx_rd_flags), 32'(flg));
        chk({tag, " tx drop_cnt"}, 32'(tx_drop_cnt), 32'(drop));
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, " rx pending"}, 32'(rx_pending), 32'd0);
        chk({tag, " rx unread"}, 32'(rx_unread), 32'd0);
        chk({tag, " rx full"}, 32'(rx_full), 32'd0);
        chk({tag, " rx switch_fail"}, 32'(rx_switch_fail), 32'd0);
        chk({tag, " rx drop_cnt"}, 32'(rx_drop_cnt), 32'd0);
        chk({tag, " rx rd_len"}, 32'(rx_rd_len), 32'd0);
        chk({tag, " rx rd_flags"}, 32'(rx_rd_flags), 32'd0);
        chk({tag, " rx mm_readdata"}, rx_mm_readdata, 32'd0);
        chk({tag, " rx rd_byte"}, 32'(rx_rd_byte), 32'd0);
        tx_state({tag, " tx"}, 2'd0, 1'b0, 9'd0, 8'h00, 8'd0);
        chk({tag, " tx mm_readdata"}, tx_mm_readdata, 32'd0);
        chk({tag, " tx rd_byte"}, 32'(tx_rd_byte), 32'd0);
    endtask

    initial begin
        // ---- vector table for the RX ring ----
        // Ten bytes into page 0, nothing committed yet
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(OP_WR, 8'(i), 8'(i), 8'h00, 3'd0, 1'b0, 9'd0, 8'h00, 8'd0, 32'h0, 32'h0));
        end
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h5A, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_MRD, 8'd0,  8'h00, 8'h00, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h03020100, 32'hFFFFFFFF));
        tbl.push_back(mk(OP_MRD, 8'd2,  8'h00, 8'h00, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h00000908, 32'h0000FFFF));
        // Page 1: write at 40, abort, write at 3 -> length 4
        tbl.push_back(mk(OP_WR,  8'd40, 8'hEE, 8'h00, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_AB,  8'd0,  8'h00, 8'h00, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_WR,  8'd3,  8'h33, 8'h00, 3'd1, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h11, 3'd2, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        // Page 2: write together with switch -> length 1, ring now full
        tbl.push_back(mk(OP_WR | OP_SW, 8'd0, 8'h77, 8'h22, 3'd3, 1'b0, 9'd10, 8'h5A, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h99, 3'd3, 1'b1, 9'd10, 8'h5A, 8'd1, 32'h0, 32'h0));
        // Switch + release while full: switch refused, release taken
        tbl.push_back(mk(OP_SW | OP_DN, 8'd0, 8'h00, 8'h98, 3'd2, 1'b1, 9'd4, 8'h11, 8'd2, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h44, 3'd3, 1'b0, 9'd4,  8'h11, 8'd2, 32'h0, 32'h0));
        tbl.push_back(mk(OP_MRD, 8'd0,  8'h00, 8'h00, 3'd3, 1'b0, 9'd4,  8'h11, 8'd2, 32'h33000000, 32'hFF000000));
        // Drop counter saturation
        for (int i = 0; i < 255; i++) begin
            tbl.push_back(mk(OP_SW, 8'd0, 8'h00, 8'h00, 3'd3, 1'b1, 9'd4, 8'h11,
                             (i + 3 > 255) ? 8'd255 : 8'(i + 3), 32'h0, 32'h0));
        end
        tbl.push_back(mk(OP_CLR | OP_SW, 8'd0, 8'h00, 8'h00, 3'd3, 1'b1, 9'd4, 8'h11, 8'd1, 32'h0, 32'h0));
        // Drain, then a release with nothing pending
        tbl.push_back(mk(OP_DN,  8'd0,  8'h00, 8'h00, 3'd2, 1'b0, 9'd1,  8'h22, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_DN,  8'd0,  8'h00, 8'h00, 3'd1, 1'b0, 9'd0,  8'h44, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_DN,  8'd0,  8'h00, 8'h00, 3'd0, 1'b0, 9'd0,  8'h00, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_DN,  8'd0,  8'h00, 8'h00, 3'd0, 1'b0, 9'd0,  8'h00, 8'd1, 32'h0, 32'h0));
        // Two pages pending plus a live tracker, then flush with a same-cycle switch
        tbl.push_back(mk(OP_WR,  8'd5,  8'h55, 8'h00, 3'd0, 1'b0, 9'd0,  8'h00, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h01, 3'd1, 1'b0, 9'd6,  8'h01, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_WR,  8'd1,  8'h11, 8'h00, 3'd1, 1'b0, 9'd6,  8'h01, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h02, 3'd2, 1'b0, 9'd6,  8'h01, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_WR,  8'd20, 8'h20, 8'h00, 3'd2, 1'b0, 9'd6,  8'h01, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_ALL | OP_SW, 8'd0, 8'h00, 8'h77, 3'd0, 1'b0, 9'd0, 8'h00, 8'd1, 32'h0, 32'h0));
        tbl.push_back(mk(OP_CLR, 8'd0,  8'h00, 8'h00, 3'd0, 1'b0, 9'd0,  8'h00, 8'd0, 32'h0, 32'h0));
        // Pointers back at page 0 and tracker cleared by the flush
        tbl.push_back(mk(OP_WR,  8'd2,  8'hA5, 8'h00, 3'd0, 1'b0, 9'd0,  8'h00, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_SW,  8'd0,  8'h00, 8'h5C, 3'd1, 1'b0, 9'd3,  8'h5C, 8'd0, 32'h0, 32'h0));
        tbl.push_back(mk(OP_MRD, 8'd0,  8'h00, 8'h00, 3'd1, 1'b0, 9'd3,  8'h5C, 8'd0, 32'h00A50000, 32'h00FF0000));

        // ---- reset ----
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_reset("reset");
        reset_n = 1'b1;

        // ---- RX table ----
        foreach (tbl[i]) begin
            apply_rx(i, tbl[i]);
        end

        // ---- TX hand-written sequence ----
        tx_mm_write = 1'b1; tx_mm_address = 6'd1; tx_mm_byteenable = 4'b0110;
        tx_mm_writedata = 32'hAABBCCDD;
        tx_tick("t1");
        tx_state("t1", 2'd0, 1'b0, 9'd0, 8'h00, 8'd0);
        tx_switch = 1'b1; tx_wr_flags = 8'h3C;
        tx_tick("t2");
        tx_state("t2", 2'd1, 1'b0, 9'd7, 8'h3C, 8'd0);
        tx_rd_en = 1'b1; tx_rd_addr = 8'd5; txq_b.push_back(8'hCC);
        tx_tick("t3");
        tx_rd_en = 1'b1; tx_rd_addr = 8'd6; txq_b.push_back(8'hBB);
        tx_tick("t4");
        tx_switch = 1'b1; tx_wr_flags = 8'hEE;
        tx_tick("t5");
        tx_state("t5", 2'd1, 1'b1, 9'd7, 8'h3C, 8'd1);
        tx_mm_write = 1'b1; tx_mm_address = 6'd0; tx_mm_byteenable = 4'b1111;
        tx_mm_writedata = 32'h12345678;
        tx_tick("t6");
        tx_state("t6", 2'd1, 1'b0, 9'd7, 8'h3C, 8'd1);
        tx_mm_write = 1'b1; tx_mm_address = 6'd0; tx_mm_byteenable = 4'b1111;
        tx_mm_writedata = 32'h9ABCDEF0; tx_mm_read = 1'b1; txq_mm.push_back(32'h12345678);
        tx_tick("t7");
        tx_mm_read = 1'b1; tx_mm_address = 6'd0; txq_mm.push_back(32'h9ABCDEF0);
        tx_wr_en = 1'b1; tx_wr_addr = 8'd50; tx_wr_byte = 8'h55;
        tx_tick("t8");
        tx_rd_done = 1'b1;
        tx_tick("t9");
        tx_state("t9", 2'd0, 1'b0, 9'd0, 8'h00, 8'd1);
        tx_switch = 1'b1; tx_wr_flags = 8'hC3;
        tx_tick("t10");
        tx_state("t10", 2'd1, 1'b0, 9'd4, 8'hC3, 8'd1);
        tx_rd_en = 1'b1; tx_rd_addr = 8'd3; txq_b.push_back(8'h9A);
        tx_tick("t11");

        // ---- reset in the middle of activity, with a read in flight ----
        rx_mm_read = 1'b1; rx_mm_address = 6'd0;
        tx_mm_read = 1'b1; tx_rd_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_reset("midreset");
        @(posedge clk);
        #1;
        chk("midreset held rx mm_readdata", rx_mm_readdata, 32'd0);
        chk("midreset held tx rd_byte", 32'(tx_rd_byte), 32'd0);
        rx_idle();
        tx_idle();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rx pending", 32'(rx_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
